// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder
// Producer end of the MAC operand interface. Accepts a coefficient table and then a
// framed sample stream over valid/ready, and turns each accepted word into a
// single-cycle write strobe (with registered data) into the MAC coefficient or
// signal FIFO. It honours the FIFO full flags and latches the MAC mode for the run.
//
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   start_i, abort_i, mode_i      run control; mode_i latched when a run starts
//   coeff_valid_i/ready_o/data_i  coefficient input channel
//   sample_valid_i/ready_o/data_i/last_i  framed sample input channel
//   coeff_full_i, signal_full_i   MAC FIFO full flags
//   coeff_wr_o, coeff_data_o      coefficient FIFO write strobe and data
//   signal_wr_o, signal_data_o    signal FIFO write strobe and data
//   mode_o, busy_o, done_o        latched mode, run active, frame-complete pulse
//   sample_cnt_o                  samples written in the current frame
module mac_stream_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_LINES = 4,
  parameter int unsigned NUM_COEFF  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  mode_i,
  input  logic                  coeff_valid_i,
  output logic                  coeff_ready_o,
  input  logic [DATA_WIDTH-1:0] coeff_data_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  input  logic [DATA_WIDTH-1:0] sample_data_i,
  input  logic                  sample_last_i,
  input  logic                  coeff_full_i,
  input  logic                  signal_full_i,
  output logic                  coeff_wr_o,
  output logic [DATA_WIDTH-1:0] coeff_data_o,
  output logic                  signal_wr_o,
  output logic [DATA_WIDTH-1:0] signal_data_o,
  output logic                  mode_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  sample_cnt_o
);

  // Coefficient index never exceeds the FIFO depth, so FIFO address width suffices.
  localparam int unsigned IDX_W = (ADDR_LINES > 0) ? ADDR_LINES : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  mode_d;
  logic                  coeff_wr_d, signal_wr_d;
  logic [DATA_WIDTH-1:0] coeff_data_d, signal_data_d;
  logic                  coeff_hs, sample_hs;

  // The !wr term absorbs the one-cycle lag of the FIFO full flag.
  assign coeff_ready_o  = (state_q == LOAD)   & ~coeff_full_i  & ~coeff_wr_o;
  assign sample_ready_o = (state_q == STREAM) & ~signal_full_i & ~signal_wr_o;
  assign coeff_hs       = coeff_valid_i  & coeff_ready_o;
  assign sample_hs      = sample_valid_i & sample_ready_o;

  // Next-state and next-register values; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = sample_cnt_o;
    mode_d        = mode_o;
    coeff_wr_d    = 1'b0;
    coeff_data_d  = coeff_data_o;
    signal_wr_d   = 1'b0;
    signal_data_d = signal_data_o;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_d  = mode_i;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (coeff_hs) begin
            coeff_wr_d   = 1'b1;
            coeff_data_d = coeff_data_i;
            idx_d        = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = STREAM;
          end
        end
        STREAM: begin
          if (sample_hs) begin
            signal_wr_d   = 1'b1;
            signal_data_d = sample_data_i;
            cnt_d         = sample_cnt_o + CNT_WIDTH'(1);
            if (sample_last_i) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; done/busy are registered decodes of the next state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sample_cnt_o  <= '0;
      mode_o        <= 1'b0;
      coeff_wr_o    <= 1'b0;
      coeff_data_o  <= '0;
      signal_wr_o   <= 1'b0;
      signal_data_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sample_cnt_o  <= cnt_d;
      mode_o        <= mode_d;
      coeff_wr_o    <= coeff_wr_d;
      coeff_data_o  <= coeff_data_d;
      signal_wr_o   <= signal_wr_d;
      signal_data_o <= signal_data_d;
      busy_o        <= (state_d != IDLE);
      done_o        <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Testbench for mac_stream_feeder: randomized framed runs checked against a
// transaction-level model (each accepted word must appear once, one cycle later,
// with the sent data; frame counts, done pulses and mode follow the run rules).
module tb_mac_stream_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned AL = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rstn_i, start_i, abort_i, mode_i;
  logic          coeff_valid_i, coeff_ready_o;
  logic [DW-1:0] coeff_data_i;
  logic          sample_valid_i, sample_ready_o, sample_last_i;
  logic [DW-1:0] sample_data_i;
  logic          coeff_full_i, signal_full_i;
  logic          coeff_wr_o, signal_wr_o;
  logic [DW-1:0] coeff_data_o, signal_data_o;
  logic          mode_o, busy_o, done_o;
  logic [CW-1:0] sample_cnt_o;

  mac_stream_feeder #(
    .DATA_WIDTH(DW), .ADDR_LINES(AL), .NUM_COEFF(NC), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o), .coeff_data_i(coeff_data_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sample_data_i(sample_data_i), .sample_last_i(sample_last_i),
    .coeff_full_i(coeff_full_i), .signal_full_i(signal_full_i),
    .coeff_wr_o(coeff_wr_o), .coeff_data_o(coeff_data_o),
    .signal_wr_o(signal_wr_o), .signal_data_o(signal_data_o),
    .mode_o(mode_o), .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned   n_checks, n_pass, cyc, full_pct;
  int unsigned   n_done_seen, n_done_exp, cnt_model;
  logic          force_cfull, force_sfull;
  logic          c_hs_seen, s_hs_seen, pend_c, pend_s;
  logic [DW-1:0] pend_c_data, pend_s_data;
  int unsigned   hc [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic drive_fulls();
    coeff_full_i  = force_cfull | ($urandom_range(99) < full_pct);
    signal_full_i = force_sfull | ($urandom_range(99) < full_pct);
  endtask

  // One clock: observe at the falling edge, update the model, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rstn_i) begin
      if (coeff_wr_o || pend_c) check("coeff_wr", 32'(coeff_wr_o), 32'(pend_c));
      if (coeff_wr_o && pend_c) check("coeff_data", coeff_data_o, pend_c_data);
      if (signal_wr_o || pend_s) check("signal_wr", 32'(signal_wr_o), 32'(pend_s));
      if (signal_wr_o && pend_s) begin
        check("signal_data", signal_data_o, pend_s_data);
        check("sample_cnt", 32'(sample_cnt_o), 32'(CW'(cnt_model)));
      end
      if (coeff_ready_o)  check("coeff_ready_rule",  32'({coeff_full_i, coeff_wr_o}), 32'd0);
      if (sample_ready_o) check("sample_ready_rule", 32'({signal_full_i, signal_wr_o}), 32'd0);
      if (done_o) n_done_seen++;
    end
    c_hs_seen = rstn_i & ~abort_i & coeff_valid_i & coeff_ready_o;
    s_hs_seen = rstn_i & ~abort_i & sample_valid_i & sample_ready_o;
    pend_c = c_hs_seen;
    if (c_hs_seen) pend_c_data = coeff_data_i;
    pend_s = s_hs_seen;
    if (s_hs_seen) begin
      pend_s_data = sample_data_i;
      cnt_model++;
    end
    @(posedge clk);
    #1;
    drive_fulls();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_coeff_wr"},   32'(coeff_wr_o), 32'd0);
    check({tag, "_signal_wr"},  32'(signal_wr_o), 32'd0);
    check({tag, "_coeff_data"}, coeff_data_o, 32'd0);
    check({tag, "_sig_data"},   signal_data_o, 32'd0);
    check({tag, "_mode"},       32'(mode_o), 32'd0);
    check({tag, "_busy"},       32'(busy_o), 32'd0);
    check({tag, "_done"},       32'(done_o), 32'd0);
    check({tag, "_cnt"},        32'(sample_cnt_o), 32'd0);
    check({tag, "_c_ready"},    32'(coeff_ready_o), 32'd0);
    check({tag, "_s_ready"},    32'(sample_ready_o), 32'd0);
  endtask

  task automatic start_run(input logic m);
    start_i = 1'b1;
    mode_i  = m;
    tick();
    start_i = 1'b0;
    mode_i  = ~m;
    cnt_model = 0;
    check("run_busy", 32'(busy_o), 32'd1);
    check("mode_latch", 32'(mode_o), 32'(m));
    check("cnt_clear", 32'(sample_cnt_o), 32'd0);
  endtask

  task automatic send_coeff(input logic [DW-1:0] d, input int unsigned gap, output int unsigned hs_cyc);
    logic ok;
    repeat (gap) tick();
    coeff_valid_i = 1'b1;
    coeff_data_i  = d;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      ok = c_hs_seen;
    end
    coeff_valid_i = 1'b0;
    check("coeff_accept", 32'(ok), 32'd1);
    hs_cyc = cyc;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic last, input int unsigned gap,
                             input logic poke);
    logic ok;
    repeat (gap) tick();
    sample_valid_i = 1'b1;
    sample_data_i  = d;
    sample_last_i  = last;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (poke) begin
        start_i       = 1'($urandom_range(1));
        mode_i        = 1'($urandom_range(1));
        coeff_valid_i = 1'($urandom_range(1));
        coeff_data_i  = $urandom;
      end
      tick();
      check("coeff_held_off", 32'(coeff_ready_o), 32'd0);
      ok = s_hs_seen;
    end
    sample_valid_i = 1'b0;
    sample_last_i  = 1'b0;
    start_i        = 1'b0;
    coeff_valid_i  = 1'b0;
    check("sample_accept", 32'(ok), 32'd1);
  endtask

  task automatic finish_frame(input logic m, input int unsigned n);
    check("done_pulse", 32'(done_o), 32'd1);
    check("frame_cnt", 32'(sample_cnt_o), 32'(CW'(n)));
    check("frame_mode", 32'(mode_o), 32'(m));
    n_done_exp++;
    tick();
    check("done_single", 32'(done_o), 32'd0);
    check("idle_after_done", 32'(busy_o), 32'd0);
  endtask

  task automatic run_frame(input logic m, input int unsigned n, input int unsigned pct,
                           input int unsigned gmax, input int hold_at, input logic poke);
    int unsigned hcyc;
    logic [DW-1:0] d;
    full_pct = pct;
    start_run(m);
    for (int i = 0; i < int'(NC); i++) send_coeff($urandom, $urandom_range(gmax), hcyc);
    for (int i = 0; i < int'(n); i++) begin
      d = $urandom;
      if (i == hold_at) begin
        // Hold the signal FIFO full for 5 cycles with a sample pending.
        force_sfull = 1'b1;
        drive_fulls();
        sample_valid_i = 1'b1;
        sample_data_i  = d;
        for (int j = 0; j < 5; j++) begin
          tick();
          check("hold_ready", 32'(sample_ready_o), 32'd0);
          check("hold_no_wr", 32'(signal_wr_o), 32'd0);
        end
        force_sfull = 1'b0;
        drive_fulls();
      end
      send_sample(d, 1'(i == int'(n) - 1), $urandom_range(gmax), poke);
    end
    finish_frame(m, n);
    full_pct = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; full_pct = 0;
    n_done_seen = 0; n_done_exp = 0; cnt_model = 0;
    force_cfull = 1'b0; force_sfull = 1'b0;
    c_hs_seen = 1'b0; s_hs_seen = 1'b0; pend_c = 1'b0; pend_s = 1'b0;
    pend_c_data = '0; pend_s_data = '0;
    rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
    coeff_valid_i = 1'b0; coeff_data_i = '0;
    sample_valid_i = 1'b0; sample_data_i = '0; sample_last_i = 1'b0;
    coeff_full_i = 1'b0; signal_full_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 32'(busy_o), 32'd0);

    // Directed table load: back-to-back words are written every other cycle.
    start_run(1'b1);
    send_coeff(32'h11, 0, hc[0]);
    send_coeff(32'h22, 0, hc[1]);
    send_coeff(32'h33, 0, hc[2]);
    send_coeff(32'h44, 0, hc[3]);
    for (int i = 1; i < 4; i++) check("coeff_spacing", hc[i] - hc[i-1], 32'd2);
    check("last_coeff_data", coeff_data_o, 32'h44);
    check("last_coeff_wr", 32'(coeff_wr_o), 32'd1);
    check("stream_ready", 32'(sample_ready_o), 32'd1);
    for (int i = 0; i < 8; i++) send_sample($urandom, 1'(i == 7), 0, 1'b0);
    finish_frame(1'b1, 8);

    // Signal FIFO full held mid-frame.
    run_frame(1'b0, 10, 0, 0, 4, 1'b0);

    // Abort after two coefficients.
    start_run(1'b1);
    send_coeff($urandom, 0, hc[0]);
    send_coeff($urandom, 0, hc[1]);
    coeff_valid_i = 1'b1;
    coeff_data_i  = $urandom;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_ready", 32'(coeff_ready_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      tick();
    end
    coeff_valid_i = 1'b0;

    // Start and abort together in IDLE: abort wins.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_idle", 32'(busy_o), 32'd0);
    tick();
    check("start_abort_idle2", 32'(busy_o), 32'd0);

    // Counter wrap with ignored starts, single-sample frame, then random frames.
    run_frame(1'b1, 17, 20, 2, -1, 1'b1);
    run_frame(1'b0, 1, 30, 1, -1, 1'b1);
    for (int f = 0; f < 8; f++)
      run_frame(1'($urandom_range(1)), $urandom_range(1, 20), $urandom_range(60),
                $urandom_range(2), -1, 1'b1);

    // Asynchronous reset while a signal strobe is high.
    start_run(1'b1);
    for (int i = 0; i < int'(NC); i++) send_coeff($urandom, 0, hc[0]);
    send_sample($urandom, 1'b0, 0, 1'b0);
    check("pre_reset_wr", 32'(signal_wr_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check_zero("async_reset");
    pend_c = 1'b0;
    pend_s = 1'b0;
    tick();
    tick();
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk);
    #1;
    check_zero("after_release");

    check("done_count", n_done_seen, n_done_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
